// File: rtl/trace_pkg.sv
// Shared definitions for the retire-stage trace buffer: FSM encoding, default depth, entry record.
package trace_pkg;

  localparam int DEFAULT_DEPTH = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] mem;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// DEPTH x 128-bit trace storage: one sync write port, one sync read port with registered output.
// Read of an address written in the same cycle returns the old contents; the output holds when re=0.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  trace_entry_t wdat,
  input  logic         re,
  input  logic [AW-1:0] raddr,
  output trace_entry_t rdat
);

  trace_entry_t mem [DEPTH];

  // Storage itself is never reset; only the output register is.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdat;
  end

  always_ff @(posedge clock) begin
    if (!reset) rdat <= '0;
    else if (re) rdat <= mem[raddr];
  end

endmodule

// File: rtl/trace_buf.sv
// Triggered retire-stage trace capture with host pop port; FSM, pointers, count and flags.
// Pop data appears one clock after an accepted rd_req; capture never stalls the core (drop or overwrite when full).
module trace_buf
  import trace_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter bit WRAP  = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic [31:0]              trig_pc,
  input  logic                     trig_any,
  input  logic [31:0]              pc,
  input  logic [31:0]              inst,
  input  logic [31:0]              aluout,
  input  logic [31:0]              memout,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_inst,
  output logic [31:0]              rd_alu,
  output logic [31:0]              rd_mem,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, empty_q, ovf_q, rv_q;
  logic          trig_hit, pop, wr_req, drop, overwrite, wr_en;
  trace_entry_t  wdat, rdat;

  assign wdat = '{pc: pc, inst: inst, alu: aluout, mem: memout};

  always_comb begin
    trig_hit  = trig_any || (pc == trig_pc);
    pop       = rd_req && !empty_q;
    wr_req    = !arm && (((state_q == ST_ARMED) && trig_hit) || (state_q == ST_CAPTURE));
    // A pop in the same cycle frees a slot, so a full buffer only loses data without one.
    drop      = wr_req && full_q && !pop && !WRAP;
    overwrite = wr_req && full_q && !pop && WRAP;
    wr_en     = wr_req && !drop;

    cnt_d = cnt_q;
    unique case ({wr_en && !overwrite, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    state_d = state_q;
    if (arm)                                       state_d = ST_ARMED;
    else if (drop)                                 state_d = ST_DONE;
    else if ((state_q == ST_ARMED) && trig_hit)    state_d = ST_CAPTURE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      empty_q <= (cnt_d == '0);
      rv_q    <= pop;
      if (wr_en)             wr_ptr <= wr_ptr + AW'(1);
      if (pop || overwrite)  rd_ptr <= rd_ptr + AW'(1);
      if (arm)                    ovf_q <= 1'b0;
      else if (drop || overwrite) ovf_q <= 1'b1;
    end
  end

  trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (wr_en && reset),
    .waddr (wr_ptr),
    .wdat  (wdat),
    .re    (pop && reset),
    .raddr (rd_ptr),
    .rdat  (rdat)
  );

  assign rd_valid = rv_q;
  assign rd_pc    = rdat.pc;
  assign rd_inst  = rdat.inst;
  assign rd_alu   = rdat.alu;
  assign rd_mem   = rdat.mem;
  assign count    = cnt_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;
  assign state    = state_q;

endmodule

// File: tb/tb_trace_buf.sv
// Bench for trace_buf: a WRAP=0 and a WRAP=1 instance share stimulus and are checked every cycle
// against a list-based reference model, plus directed scenario expectations.
module tb_trace_buf;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] mem;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset, arm, trig_any, rd_req;
  logic [31:0] trig_pc, pc, inst, aluout, memout;

  logic [1:0]       o_rv, o_full, o_empty, o_ovf;
  logic [1:0][31:0] o_pc, o_inst, o_alu, o_mem;
  logic [1:0][4:0]  o_cnt;
  logic [1:0][1:0]  o_st;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: entries held oldest-first in a plain list
  ent_t mlist [2][16];
  int   mcnt [2];
  int   mst [2];
  bit   movf [2];
  bit   mrv [2];
  ent_t mrd [2];

  always #5 clock = ~clock;

  trace_buf #(.DEPTH(16), .WRAP(1'b0)) u_nw (
    .clock(clock), .reset(reset), .arm(arm), .trig_pc(trig_pc), .trig_any(trig_any),
    .pc(pc), .inst(inst), .aluout(aluout), .memout(memout), .rd_req(rd_req),
    .rd_valid(o_rv[0]), .rd_pc(o_pc[0]), .rd_inst(o_inst[0]), .rd_alu(o_alu[0]), .rd_mem(o_mem[0]),
    .count(o_cnt[0]), .full(o_full[0]), .empty(o_empty[0]), .overflow(o_ovf[0]), .state(o_st[0])
  );

  trace_buf #(.DEPTH(16), .WRAP(1'b1)) u_w (
    .clock(clock), .reset(reset), .arm(arm), .trig_pc(trig_pc), .trig_any(trig_any),
    .pc(pc), .inst(inst), .aluout(aluout), .memout(memout), .rd_req(rd_req),
    .rd_valid(o_rv[1]), .rd_pc(o_pc[1]), .rd_inst(o_inst[1]), .rd_alu(o_alu[1]), .rd_mem(o_mem[1]),
    .count(o_cnt[1]), .full(o_full[1]), .empty(o_empty[1]), .overflow(o_ovf[1]), .state(o_st[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic shift_out(input int w);
    for (int i = 0; i < 15; i++) mlist[w][i] = mlist[w][i+1];
  endtask

  task automatic model_step(input int w);
    ent_t e;
    bit   popv, wr, was_full;
    e = {pc, inst, aluout, memout};
    if (!reset) begin
      mst[w] = 0; mcnt[w] = 0; movf[w] = 0; mrv[w] = 0; mrd[w] = '0;
      return;
    end
    popv     = rd_req && (mcnt[w] > 0);
    wr       = !arm && (((mst[w] == 1) && (trig_any || pc == trig_pc)) || (mst[w] == 2));
    was_full = (mcnt[w] == 16);
    mrv[w]   = popv;
    if (popv) begin
      mrd[w] = mlist[w][0];
      shift_out(w);
      mcnt[w]--;
    end
    if (wr) begin
      if (was_full && !popv) begin
        movf[w] = 1;
        if (w == 1) begin
          shift_out(w);
          mlist[w][15] = e;
        end else begin
          mst[w] = 3;
        end
      end else begin
        mlist[w][mcnt[w]] = e;
        mcnt[w]++;
      end
    end
    if (arm) begin
      mst[w] = 1;
      movf[w] = 0;
    end else if (mst[w] == 1 && wr) begin
      mst[w] = 2;
    end
  endtask

  // One clock: advance the model on the current inputs, take the edge, compare everything.
  task automatic cyc();
    model_step(0);
    model_step(1);
    @(posedge clock);
    #1;
    for (int w = 0; w < 2; w++) begin
      check($sformatf("w%0d_state", w), 32'(o_st[w]), 32'(mst[w]));
      check($sformatf("w%0d_count", w), 32'(o_cnt[w]), 32'(mcnt[w]));
      check($sformatf("w%0d_full", w), 32'(o_full[w]), 32'(mcnt[w] == 16));
      check($sformatf("w%0d_empty", w), 32'(o_empty[w]), 32'(mcnt[w] == 0));
      check($sformatf("w%0d_ovf", w), 32'(o_ovf[w]), 32'(movf[w]));
      check($sformatf("w%0d_rdv", w), 32'(o_rv[w]), 32'(mrv[w]));
      check($sformatf("w%0d_rdpc", w), o_pc[w], mrd[w].pc);
      check($sformatf("w%0d_rdinst", w), o_inst[w], mrd[w].inst);
      check($sformatf("w%0d_rdalu", w), o_alu[w], mrd[w].alu);
      check($sformatf("w%0d_rdmem", w), o_mem[w], mrd[w].mem);
    end
  endtask

  task automatic quiet();
    reset = 1'b1; arm = 1'b0; trig_any = 1'b0; rd_req = 1'b0;
    trig_pc = 32'hFFFF_FFF0;
  endtask

  task automatic rand_data();
    inst = $urandom; aluout = $urandom; memout = $urandom;
  endtask

  task automatic reset_pulse();
    reset = 1'b0; cyc(); reset = 1'b1;
  endtask

  task automatic do_arm();
    arm = 1'b1; cyc(); arm = 1'b0;
  endtask

  int rd_pct;

  initial begin
    quiet();
    pc = '0; inst = '0; aluout = '0; memout = '0;
    reset = 1'b0;
    cyc(); cyc();
    check("rst_count", 32'(o_cnt[0]), 0);
    check("rst_empty", 32'(o_empty[0]), 1);
    check("rst_state", 32'(o_st[0]), 0);
    check("rst_rdpc", o_pc[0], 0);
    reset = 1'b1;

    // Scenario 1: trig_any capture of three entries, then hold in ARMED and read back
    do_arm();
    trig_any = 1'b1;
    for (int i = 0; i < 3; i++) begin pc = 32'(i * 4); rand_data(); cyc(); end
    check("s1_count", 32'(o_cnt[0]), 3);
    check("s1_state", 32'(o_st[0]), 2);
    trig_any = 1'b0; pc = 32'h100;
    do_arm();
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("s1_rdv", 32'(o_rv[0]), 1);
      check("s1_rdpc", o_pc[0], 32'(i * 4));
    end
    rd_req = 1'b0;
    cyc();
    check("s1_hold_rdv", 32'(o_rv[0]), 0);
    check("s1_hold_rdpc", o_pc[0], 32'h8);

    // Scenario 2: PC-match trigger
    reset_pulse();
    trig_pc = 32'h20; pc = '0;
    do_arm();
    for (int i = 0; i < 11; i++) begin pc = 32'(i * 4); rand_data(); cyc(); end
    check("s2_count", 32'(o_cnt[0]), 3);
    trig_pc = 32'hFFFF_FFF0;
    do_arm();
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    check("s2_first", o_pc[0], 32'h20);

    // Scenarios 3/4: 20 capture cycles into 16 entries, stop vs wrap
    reset_pulse();
    do_arm();
    trig_any = 1'b1;
    for (int i = 0; i < 20; i++) begin pc = 32'(i * 4); rand_data(); cyc(); end
    check("s3_count", 32'(o_cnt[0]), 16);
    check("s3_full", 32'(o_full[0]), 1);
    check("s3_ovf", 32'(o_ovf[0]), 1);
    check("s3_state", 32'(o_st[0]), 3);
    check("s4_count", 32'(o_cnt[1]), 16);
    check("s4_ovf", 32'(o_ovf[1]), 1);
    check("s4_state", 32'(o_st[1]), 2);
    trig_any = 1'b0; pc = 32'h100;
    do_arm();
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i == 0) begin
        check("s3_first", o_pc[0], 32'h0);
        check("s4_first", o_pc[1], 32'h10);
      end
      if (i == 15) begin
        check("s3_last", o_pc[0], 32'h3C);
        check("s4_last", o_pc[1], 32'h4C);
      end
    end
    rd_req = 1'b0;
    cyc();
    check("s4_drained", 32'(o_empty[1]), 1);

    // Scenario 5: pop on empty, then write+pop at count 5
    reset_pulse();
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    check("s5_empty_rdv", 32'(o_rv[0]), 0);
    check("s5_empty_cnt", 32'(o_cnt[0]), 0);
    do_arm();
    trig_any = 1'b1;
    for (int i = 0; i < 5; i++) begin pc = 32'(i * 4); rand_data(); cyc(); end
    check("s5_pre_cnt", 32'(o_cnt[0]), 5);
    rd_req = 1'b1; pc = 32'h14; cyc(); rd_req = 1'b0;
    check("s5_wrpop_cnt", 32'(o_cnt[0]), 5);
    check("s5_wrpop_rdpc", o_pc[0], 32'h0);
    trig_any = 1'b0; pc = 32'h100;
    do_arm();

    // Scenario 6: reset mid-capture wins over arm and rd_req
    reset_pulse();
    do_arm();
    trig_any = 1'b1;
    for (int i = 0; i < 7; i++) begin pc = 32'(i * 4); rand_data(); cyc(); end
    check("s6_pre_cnt", 32'(o_cnt[0]), 7);
    reset = 1'b0; arm = 1'b1; rd_req = 1'b1;
    cyc();
    check("s6_count", 32'(o_cnt[0]), 0);
    check("s6_empty", 32'(o_empty[0]), 1);
    check("s6_state", 32'(o_st[0]), 0);
    check("s6_ovf", 32'(o_ovf[0]), 0);
    check("s6_rdv", 32'(o_rv[0]), 0);
    quiet();

    // Random traffic with fill/drain phases
    rd_pct = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) rd_pct = int'($urandom_range(5, 70));
      reset    = ($urandom_range(0, 299) != 0);
      arm      = ($urandom_range(0, 29) == 0);
      trig_any = ($urandom_range(0, 3) == 0);
      trig_pc  = 32'($urandom_range(0, 63)) << 2;
      pc       = 32'($urandom_range(0, 63)) << 2;
      rand_data();
      rd_req   = (int'($urandom_range(0, 99)) < rd_pct);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
